assoc_layer: RTL and testbench

Associative stage of the GAM pipeline, directly downstream of the memory layer. Buffers (key class, response class) pairs, and on `assoc_learning_start` drains them into a saturating class-to-class association weight matrix. Pulses `assoc_learning_done` back to the memory layer when the buffer is drained. While idle, it answers recall queries by returning the strongest associated response class for a key.

---
 rtl/assoc_layer_pkg.sv | 16 +
 rtl/assoc_layer_pair_fifo.sv | 52 +++++
 rtl/assoc_layer.sv | 143 ++++++++++++++
 tb/tb_assoc_layer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/assoc_layer_pkg.sv
// Shared GAM pipeline types used by the associative stage and its pair buffer.
package GAM_package;
    localparam int GAM_NUM_CLASSES = 16;
    localparam int GAM_CIW         = $clog2(GAM_NUM_CLASSES);
    localparam int ASSOC_WW        = 8;
    localparam logic [ASSOC_WW-1:0] ASSOC_WMAX = '1;

    typedef enum logic [2:0] {IDLE, LEARN, WRITE, DONE, QUERY} assoc_state_T;

    typedef logic [GAM_CIW-1:0] class_idx_T;

    typedef struct packed {
        class_idx_T key;
        class_idx_T resp;
    } assoc_pair_T;
endpackage

// File: rtl/assoc_layer_pair_fifo.sv
// Synchronous FIFO of (key, response) pairs; full/empty decoded from an occupancy count.
module assoc_pair_fifo
    import GAM_package::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  assoc_pair_T din,
    input  logic        pop,
    output assoc_pair_T dout,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    assoc_pair_T    mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/assoc_layer.sv
// Associative stage: learns saturating class-to-class weights from buffered pairs
// and answers argmax recall queries while idle.
//
// state | meaning
// IDLE  | waiting for a learning start or a recall query
// LEARN | pop next pair and read its weight, or finish when the buffer is empty
// WRITE | write back the incremented (saturated) weight
// DONE  | one-cycle learning-done pulse
// QUERY | scan one response class per cycle tracking the strongest weight
module assoc_layer
    import GAM_package::*;
#(
    parameter int NUM_CLASSES = 16,
    parameter int WW          = 8,
    parameter int FIFO_DEPTH  = 8,
    localparam int CIW        = $clog2(NUM_CLASSES)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           pair_valid,
    output logic           pair_ready,
    input  logic [CIW-1:0] key_class,
    input  logic [CIW-1:0] resp_class,
    input  logic           assoc_learning_start,
    output logic           assoc_learning_done,
    input  logic           query_valid,
    output logic           query_ready,
    input  logic [CIW-1:0] query_key,
    output logic           result_valid,
    output logic [CIW-1:0] result_class,
    output logic [WW-1:0]  result_weight
);
    localparam logic [WW-1:0] WMAX     = {WW{1'b1}};
    localparam class_idx_T    LAST_IDX = class_idx_T'(NUM_CLASSES - 1);

    assoc_state_T   state;
    logic [WW-1:0]  weight [NUM_CLASSES][NUM_CLASSES];
    assoc_pair_T    pair_in;
    assoc_pair_T    fifo_head;
    assoc_pair_T    cur_pair;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic [WW-1:0]  cur_w;
    logic [WW-1:0]  best_w;
    logic [WW-1:0]  scan_w;
    class_idx_T     query_key_q;
    class_idx_T     scan_idx;
    class_idx_T     best_idx;
    logic           scan_gt;

    assign pair_in.key  = class_idx_T'(key_class);
    assign pair_in.resp = class_idx_T'(resp_class);
    assign pair_ready   = !fifo_full;
    assign query_ready  = (state == IDLE);
    assign fifo_pop     = (state == LEARN) && !fifo_empty;
    assign scan_w       = weight[query_key_q][scan_idx];
    // strict compare keeps the lowest index on ties
    assign scan_gt      = (scan_w > best_w);

    assoc_pair_fifo #(.DEPTH(FIFO_DEPTH)) u_pair_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pair_valid),
        .din   (pair_in),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state               <= IDLE;
            assoc_learning_done <= 1'b0;
            result_valid        <= 1'b0;
            result_class        <= '0;
            result_weight       <= '0;
            query_key_q         <= '0;
            scan_idx            <= '0;
            best_idx            <= '0;
            best_w              <= '0;
            cur_pair            <= '0;
            cur_w               <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                for (int r = 0; r < NUM_CLASSES; r++) begin
                    weight[k][r] <= '0;
                end
            end
        end else begin
            assoc_learning_done <= 1'b0;
            result_valid        <= 1'b0;
            case (state)
                IDLE: begin
                    if (assoc_learning_start) begin
                        state <= LEARN;
                    end else if (query_valid) begin
                        state       <= QUERY;
                        query_key_q <= class_idx_T'(query_key);
                        scan_idx    <= '0;
                        best_idx    <= '0;
                        best_w      <= '0;
                    end
                end
                LEARN: begin
                    if (!fifo_empty) begin
                        cur_pair <= fifo_head;
                        cur_w    <= weight[fifo_head.key][fifo_head.resp];
                        state    <= WRITE;
                    end else begin
                        assoc_learning_done <= 1'b1;
                        state               <= DONE;
                    end
                end
                WRITE: begin
                    // self-associations pass through the buffer but never touch the matrix
                    if ((cur_pair.key != cur_pair.resp) && (cur_w != WMAX)) begin
                        weight[cur_pair.key][cur_pair.resp] <= cur_w + 1'b1;
                    end
                    state <= LEARN;
                end
                DONE: begin
                    state <= IDLE;
                end
                QUERY: begin
                    if (scan_gt) begin
                        best_w   <= scan_w;
                        best_idx <= scan_idx;
                    end
                    if (scan_idx == LAST_IDX) begin
                        result_valid  <= 1'b1;
                        result_class  <= scan_gt ? scan_idx : best_idx;
                        result_weight <= scan_gt ? scan_w : best_w;
                        state         <= IDLE;
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_assoc_layer.sv
// Self-checking bench for assoc_layer: directed corner cases plus random learn/recall rounds
// against a queue-and-array reference model.
module tb_assoc_layer;
    localparam int NC    = 16;
    localparam int CW    = 4;
    localparam int TW    = 2;
    localparam int DEPTH = 8;
    localparam int WMAXI = (1 << TW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          pair_valid;
    logic          pair_ready;
    logic [CW-1:0] key_class;
    logic [CW-1:0] resp_class;
    logic          assoc_learning_start;
    logic          assoc_learning_done;
    logic          query_valid;
    logic          query_ready;
    logic [CW-1:0] query_key;
    logic          result_valid;
    logic [CW-1:0] result_class;
    logic [TW-1:0] result_weight;

    int tests_run    = 0;
    int tests_failed = 0;

    int model_w [NC][NC];
    int model_q_key[$];
    int model_q_resp[$];

    always #5 clk = ~clk;

    assoc_layer #(.NUM_CLASSES(NC), .WW(TW), .FIFO_DEPTH(DEPTH)) dut (
        .clk                  (clk),
        .reset                (reset),
        .pair_valid           (pair_valid),
        .pair_ready           (pair_ready),
        .key_class            (key_class),
        .resp_class           (resp_class),
        .assoc_learning_start (assoc_learning_start),
        .assoc_learning_done  (assoc_learning_done),
        .query_valid          (query_valid),
        .query_ready          (query_ready),
        .query_key            (query_key),
        .result_valid         (result_valid),
        .result_class         (result_class),
        .result_weight        (result_weight)
    );

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NC; k++)
            for (int r = 0; r < NC; r++)
                model_w[k][r] = 0;
        model_q_key.delete();
        model_q_resp.delete();
    endtask

    task automatic model_drain();
        while (model_q_key.size() > 0) begin
            int k, r;
            k = model_q_key.pop_front();
            r = model_q_resp.pop_front();
            if (k != r && model_w[k][r] < WMAXI) model_w[k][r]++;
        end
    endtask

    // One clock: an offered pair counts as accepted if ready was high going into the edge.
    task automatic step();
        logic acc;
        acc = pair_valid && pair_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            model_q_key.push_back(int'(key_class));
            model_q_resp.push_back(int'(resp_class));
            pair_valid = 1'b0;
        end
    endtask

    task automatic push_pair(input int k, input int r);
        int n;
        pair_valid = 1'b1;
        key_class  = CW'(k);
        resp_class = CW'(r);
        n = 0;
        while (pair_valid && n < 50) begin
            step();
            n++;
        end
        if (pair_valid) begin
            check("push_timeout", 1, 0);
            pair_valid = 1'b0;
        end
    endtask

    task automatic learn(input int exp_lat);
        int k;
        assoc_learning_start = 1'b1;
        step();
        assoc_learning_start = 1'b0;
        k = 1;
        while (!assoc_learning_done && k < 200) begin
            step();
            k++;
        end
        check("learn_latency", k, exp_lat);
        step();
        check("done_one_cycle", int'(assoc_learning_done), 0);
        model_drain();
    endtask

    task automatic query(input int key, input bit poke_start);
        int k, exp_c, exp_w, n_done;
        exp_c = 0;
        exp_w = 0;
        for (int i = 0; i < NC; i++) begin
            if (model_w[key][i] > exp_w) begin
                exp_w = model_w[key][i];
                exp_c = i;
            end
        end
        check("query_ready_idle", int'(query_ready), 1);
        query_valid = 1'b1;
        query_key   = CW'(key);
        step();
        query_valid = 1'b0;
        k = 1;
        n_done = 0;
        while (!result_valid && k < 200) begin
            if (k == 3) check("query_ready_busy", int'(query_ready), 0);
            assoc_learning_start = poke_start && (k == 5);
            step();
            if (assoc_learning_done) n_done++;
            k++;
        end
        assoc_learning_start = 1'b0;
        check("query_latency", k, NC + 1);
        check("result_class", int'(result_class), exp_c);
        check("result_weight", int'(result_weight), exp_w);
        step();
        check("result_one_cycle", int'(result_valid), 0);
        check("result_hold", int'(result_class), exp_c);
        if (poke_start) begin
            for (int i = 0; i < 5; i++) begin
                step();
                if (assoc_learning_done) n_done++;
            end
            check("start_in_query_ignored", n_done, 0);
        end
    endtask

    initial begin
        int n_done, n;
        reset                = 1'b0;
        pair_valid           = 1'b0;
        key_class            = '0;
        resp_class           = '0;
        assoc_learning_start = 1'b0;
        query_valid          = 1'b0;
        query_key            = '0;
        model_clear();
        step();
        step();
        reset = 1'b1;
        check("rst_pair_ready", int'(pair_ready), 1);
        check("rst_query_ready", int'(query_ready), 1);
        check("rst_done", int'(assoc_learning_done), 0);
        check("rst_result_valid", int'(result_valid), 0);
        check("rst_result_class", int'(result_class), 0);
        check("rst_result_weight", int'(result_weight), 0);

        learn(2);
        query(3, 1'b0);

        for (int i = 0; i < 3; i++) push_pair(2, 5);
        push_pair(2, 7);
        learn(10);
        query(2, 1'b0);

        for (int i = 0; i < DEPTH; i++) push_pair(9, i);
        check("full_ready_low", int'(pair_ready), 0);
        pair_valid = 1'b1;
        key_class  = CW'(9);
        resp_class = CW'(10);
        for (int i = 0; i < 3; i++) step();
        check("ninth_held", model_q_key.size(), DEPTH);
        learn(2 * (DEPTH + 1) + 2);
        check("ninth_accepted", int'(pair_valid), 0);
        query(9, 1'b0);

        for (int i = 0; i < 5; i++) push_pair(1, 4);
        learn(12);
        check("sat_model", model_w[1][4], WMAXI);
        for (int i = 0; i < 3; i++) push_pair(1, 6);
        learn(8);
        query(1, 1'b0);

        push_pair(6, 6);
        learn(4);
        query(6, 1'b1);

        push_pair(3, 4);
        push_pair(3, 4);
        assoc_learning_start = 1'b1;
        step();
        assoc_learning_start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        model_clear();
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (assoc_learning_done) n_done++;
            step();
        end
        check("reset_abort_no_done", n_done, 0);
        check("reset_abort_ready", int'(pair_ready), 1);
        query(3, 1'b0);
        query(2, 1'b0);

        for (int round = 0; round < 8; round++) begin
            n = int'($urandom_range(0, DEPTH));
            for (int i = 0; i < n; i++)
                push_pair(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)));
            learn(2 * n + 2);
            query(int'($urandom_range(0, 3)), 1'b0);
            query(int'($urandom_range(0, 3)), round[0]);
            query(int'($urandom_range(0, NC - 1)), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
